// File: rtl/cic_decimator.sv
// N-stage CIC decimator with power-of-two decimation, rounded/saturated output scaling
// and a registered pass-through bypass.
module cic_decimator #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int NUM_STAGES   = 3,
  parameter int MAX_DEC_LOG2 = 5,
  localparam int DEC_W       = $clog2(MAX_DEC_LOG2 + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic                         bypass,
  input  logic [DEC_W-1:0]             dec_log2,
  input  logic signed [DATA_WIDTH-1:0] cic_in,
  output logic signed [DATA_WIDTH-1:0] cic_out,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         valid_out
);

  localparam int ACC_WIDTH = DATA_WIDTH + NUM_STAGES * MAX_DEC_LOG2;
  localparam int CNT_W     = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH + 1)'(1);

  logic [DEC_W-1:0]            dec_clamp;
  logic [DEC_W-1:0]            dec_reg;
  logic                        dec_chg;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W:0]              d_full;
  logic                        strobe;
  logic signed [ACC_WIDTH-1:0] integ     [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] integ_nxt [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] dly       [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] comb      [NUM_STAGES+1];
  logic signed [ACC_WIDTH:0]   c_ext;
  logic signed [ACC_WIDTH:0]   round_add;
  logic signed [ACC_WIDTH:0]   scaled;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [DATA_WIDTH-1:0]       sat_val;
  int                          shift;

  assign dec_clamp = (dec_log2 > DEC_W'(MAX_DEC_LOG2)) ? DEC_W'(MAX_DEC_LOG2) : dec_log2;
  assign dec_chg   = (dec_clamp != dec_reg);
  assign d_full    = (CNT_W + 1)'(1) << dec_reg;
  assign strobe    = ({1'b0, cnt} == (d_full - (CNT_W + 1)'(1)));

  always_comb begin
    integ_nxt[0] = integ[0] + {{(ACC_WIDTH - DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
    for (int k = 1; k < NUM_STAGES; k++) begin
      integ_nxt[k] = integ[k] + integ_nxt[k-1];
    end
    comb[0] = integ_nxt[NUM_STAGES-1];
    for (int k = 1; k <= NUM_STAGES; k++) begin
      comb[k] = comb[k-1] - dly[k-1];
    end
  end

  // Gain of the filter is D^N = 2^(N*dec_log2), removed with round-half-up before saturating.
  always_comb begin
    shift     = NUM_STAGES * int'(dec_reg);
    c_ext     = {comb[NUM_STAGES][ACC_WIDTH-1], comb[NUM_STAGES]};
    round_add = (shift > 0) ? ((ACC_WIDTH + 1)'(1) << (shift - 1)) : '0;
    scaled    = (c_ext + round_add) >>> shift;
    sat_hi    = (scaled > SAT_MAX);
    sat_lo    = (scaled < SAT_MIN);
    sat_val   = sat_hi ? {1'b0, {(DATA_WIDTH - 1){1'b1}}} :
                sat_lo ? {1'b1, {(DATA_WIDTH - 1){1'b0}}} : scaled[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_reg   <= '0;
      cnt       <= '0;
      cic_out   <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dec_reg   <= dec_clamp;
      if (bypass || dec_chg) begin
        // Filter history is discarded whenever the decimation ratio or mode changes.
        cnt <= '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
          integ[k] <= '0;
          dly[k]   <= '0;
        end
        if (bypass) begin
          valid_out <= valid_in;
          if (valid_in) cic_out <= cic_in;
        end
      end else if (valid_in) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          integ[k] <= integ_nxt[k];
        end
        if (strobe) begin
          cnt <= '0;
          for (int k = 0; k < NUM_STAGES; k++) begin
            dly[k] <= comb[k];
          end
          cic_out   <= sat_val;
          valid_out <= 1'b1;
          overflow  <= sat_hi;
          underflow <= sat_lo;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
